// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy state encoding and counter step.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_OCC_W    = 2;
    localparam int PIPE_CNT_STEP = 1;

    function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot (control + data) of the elastic stage; clearing drops only the control field.
module pipe_entry_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 160
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end else if (clr) begin
            q_ctrl <= '0;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage: main + skid entry, registered in_ready, flush to bubble.
// Optional perf counters (stall_cnt/bubble_cnt) built only with ELASTIC_PIPE_PERF_EN.
//
// state    | meaning
// PS_EMPTY | no entry held, out_valid low
// PS_ONE   | head in main reg
// PS_TWO   | head in main reg, next entry in skid reg, in_ready low
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 160,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef ELASTIC_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    pipe_state_t       state, state_nx;
    logic              accept, pop;
    logic              main_ld, main_clr, skid_ld, skid_clr;
    logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] skid_data, main_data_d;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        main_ld  = 1'b0;
        skid_ld  = 1'b0;
        main_clr = flush;
        skid_clr = flush;
        if (flush) begin
            state_nx = PS_EMPTY;
        end else begin
            case (state)
                PS_EMPTY: if (accept) begin
                    state_nx = PS_ONE;
                    main_ld  = 1'b1;
                end
                PS_ONE: begin
                    if (accept && pop) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_nx = PS_TWO;
                        skid_ld  = 1'b1;
                    end else if (pop) begin
                        state_nx = PS_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                PS_TWO: if (pop) begin
                    state_nx = PS_ONE;
                    main_ld  = 1'b1;
                    skid_clr = 1'b1;
                end
                default: state_nx = PS_EMPTY;
            endcase
        end
    end

    // Main refills from the skid slot when draining TWO, otherwise from upstream.
    assign main_ctrl_d = (state == PS_TWO) ? skid_ctrl : in_ctrl;
    assign main_data_d = (state == PS_TWO) ? skid_data : in_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= PS_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx != PS_TWO);
            out_valid <= (state_nx != PS_EMPTY);
        end
    end

    assign occupancy = occ_of(state);

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_ld),
        .clr    (main_clr),
        .d_ctrl (main_ctrl_d),
        .d_data (main_data_d),
        .q_ctrl (out_ctrl),
        .q_data (out_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_ld),
        .clr    (skid_clr),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

`ifdef ELASTIC_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(PIPE_CNT_STEP);
            if (!out_valid && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_W'(PIPE_CNT_STEP);
        end
    end
`else
    logic [31:0] unused_cnt_w;
    assign unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Randomized + directed bench for elastic_pipe_reg against a queue-based FIFO model.
module tb_elastic_pipe_reg;

    localparam int CW      = 8;
    localparam int DW      = 32;
    localparam int NW      = 4;
    localparam int CNT_MAX = 15;

    logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
`ifdef ELASTIC_PIPE_PERF_EN
    logic [NW-1:0] stall_cnt, bubble_cnt;
`endif

    elastic_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef ELASTIC_PIPE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_data;
    int            m_stall, m_bubble;
    int            n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (q.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("out_ctrl", 64'(out_ctrl), ev ? 64'(q[0].c) : 64'd0);
        chk("out_data", 64'(out_data), ev ? 64'(q[0].d) : 64'(m_data));
        chk("ctrl_idle", 64'(!out_valid && out_ctrl != '0), 64'd0);
`ifdef ELASTIC_PIPE_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
    endtask

    // Drive one cycle: check current outputs, then advance the model by the same edge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy);
        int  n;
        logic pop_e, acc_e;
        rst = r; flush = f; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
        @(negedge clk);
        check_outputs();
        if (!r) begin
            q.delete();
            m_data = '0; m_stall = 0; m_bubble = 0;
        end else begin
            n = q.size();
            pop_e = (n != 0) && ordy;
            acc_e = iv && (n != 2) && !f;
            if (n != 0 && !ordy && m_stall < CNT_MAX) m_stall++;
            if (n == 0 && m_bubble < CNT_MAX) m_bubble++;
            if (pop_e) void'(q.pop_front());
            if (f) q.delete();
            else if (acc_e) q.push_back({ic, id});
            if (q.size() != 0) m_data = q[0].d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k, input logic ordy);
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, ordy);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        q.delete(); m_data = '0; m_stall = 0; m_bubble = 0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset held with a live offer
        step(1'b0, 1'b0, 1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b1);
        idle(1, 1'b1);
        chk("rst_release_ready", 64'(in_ready), 64'd1);

        // back-to-back stream
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, CW'(i + 1), DW'(32'h11 + i), 1'b1);
        idle(2, 1'b1);

        // backpressure: A,B accepted, C waits until room
        step(1'b1, 1'b0, 1'b1, 8'hA1, 32'hA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hB2, 32'hB, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hC3, 32'hC, 1'b0);
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_not_ready", 64'(in_ready), 64'd0);
        step(1'b1, 1'b0, 1'b1, 8'hC3, 32'hC, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'hC3, 32'hC, 1'b1);
        idle(3, 1'b1);

        // flush at occupancy 2 with an offer
        step(1'b1, 1'b0, 1'b1, 8'h21, 32'h21, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h22, 32'h22, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h23, 32'h23, 1'b0);
        chk("flush_occ0", 64'(occupancy), 64'd0);
        chk("flush_ctrl0", 64'(out_ctrl), 64'd0);
        idle(2, 1'b1);

        // accept and pop in the same cycle at occupancy 1
        step(1'b1, 1'b0, 1'b1, 8'h05, 32'h5, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h06, 32'h6, 1'b1);
        chk("ap_occ1", 64'(occupancy), 64'd1);
        chk("ap_data6", 64'(out_data), 64'h6);
        idle(2, 1'b1);

        // long stall, then flush must not touch counters
        step(1'b1, 1'b0, 1'b1, 8'h77, 32'h77, 1'b0);
        idle(20, 1'b0);
`ifdef ELASTIC_PIPE_PERF_EN
        chk("stall_sat", 64'(stall_cnt), 64'd15);
`endif
        step(1'b1, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
        idle(20, 1'b1);
`ifdef ELASTIC_PIPE_PERF_EN
        chk("bubble_sat", 64'(bubble_cnt), 64'd15);
        chk("stall_kept", 64'(stall_cnt), 64'd15);
`endif

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0), 1'($urandom),
                 CW'($urandom), DW'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
